instr_fetch_unit: RTL and testbench

Fetch stage of the RV32I core, directly upstream of the instruction memory and feeding the decode stage. Owns the program counter and issues one word address per cycle to the synchronous-read instruction memory, which has a 1-cycle latency. Tags each returned word with its PC and presents it to decode. Handles decode back-pressure (stall) and branch/jump redirects (flush), so decode always sees a correct (pc, instr, valid) triple.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_hold_buf.sv | 35 +++
 rtl/instr_fetch_unit.sv | 69 ++++++
 tb/tb_instr_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the RV32I fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0033;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_hold_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - stall hold buffer and presented-instruction mux
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            eff_valid,
  input  logic [XLEN-1:0] imem_word,
  output logic [XLEN-1:0] instr_out
);
  fetch_hold_e     state_q;
  logic [XLEN-1:0] hold_instr_q;

  // Only the first stalled cycle still sees the F2 word on the memory bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      hold_instr_q <= NOP_INSTR;
    end else if (flush) begin
      state_q <= RUN;
    end else if (stall) begin
      if (state_q == RUN) begin
        hold_instr_q <= imem_word;
      end
      state_q <= HOLD;
    end else begin
      state_q <= RUN;
    end
  end

  assign instr_out = !eff_valid         ? NOP_INSTR    :
                     (state_q == HOLD)  ? hold_instr_q : imem_word;
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - two-stage PC/tag pipeline with stall and redirect
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_word,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic            misalign_err
);
  logic [XLEN-1:0] pc_f1_q, pc_f1_d;
  logic [XLEN-1:0] pc_f2_q, pc_f2_d;
  logic            valid_f2_q, valid_f2_d;
  logic            misalign_q, misalign_d;

  always_comb begin
    pc_f1_d    = pc_f1_q;
    pc_f2_d    = pc_f2_q;
    valid_f2_d = valid_f2_q;
    misalign_d = 1'b0;
    if (redirect_valid) begin
      pc_f1_d    = {redirect_target[XLEN-1:2], 2'b00};
      valid_f2_d = 1'b0;
      misalign_d = |redirect_target[1:0];
    end else if (!stall) begin
      pc_f1_d    = pc_f1_q + PC_STEP;
      pc_f2_d    = pc_f1_q;
      valid_f2_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f1_q    <= RESET_PC;
      pc_f2_q    <= '0;
      valid_f2_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_f1_q    <= pc_f1_d;
      pc_f2_q    <= pc_f2_d;
      valid_f2_q <= valid_f2_d;
      misalign_q <= misalign_d;
    end
  end

  // The F2 instruction is younger than the redirecting branch, so kill it now.
  assign if_id_valid  = valid_f2_q & ~redirect_valid;
  assign if_id_pc     = pc_f2_q;
  assign imem_addr    = pc_f1_q;
  assign misalign_err = misalign_q;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (redirect_valid),
    .eff_valid (if_id_valid),
    .imem_word (imem_word),
    .instr_out (if_id_instr)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_word, if_id_pc, if_id_instr;
  logic        if_id_valid, misalign_err;
  logic [31:0] imem_addr2, imem_word2, if_id_pc2, if_id_instr2;
  logic        if_id_valid2, misalign_err2;

  instr_fetch_unit #(.RESET_PC(32'h0000_0004)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_word(imem_word),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .misalign_err(misalign_err)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_target(32'h0), .imem_addr(imem_addr2), .imem_word(imem_word2),
    .if_id_valid(if_id_valid2), .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
    .misalign_err(misalign_err2)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'd4:   return 32'h0091_0193;
      32'd8:   return 32'h0000_0033;
      32'd16:  return 32'h0051_8213;
      default: return a * 32'h9E37_79B1 + 32'h0000_1001;
    endcase
  endfunction

  always @(posedge clk) begin
    imem_word  <= mem_fn(imem_addr);
    imem_word2 <= mem_fn(imem_addr2);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected architectural PC stream: restarts on reset and on every redirect.
  logic [31:0] exp_q[$];
  logic [31:0] stream_next = 32'h4;

  task automatic step(input logic rn, input logic st, input logic rv, input logic [31:0] tg);
    @(posedge clk);
    #1;
    rst_n = rn; stall = st; redirect_valid = rv; redirect_target = tg;
    if (!rn) begin
      exp_q.delete();
      stream_next = 32'h4;
    end else if (rv) begin
      exp_q.delete();
      stream_next = {tg[31:2], 2'b00};
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(stream_next);
      stream_next = stream_next + 32'd4;
    end
    @(negedge clk);
  endtask

  logic        have_prev = 1'b0;
  logic        p_rn, p_st, p_rv, p_valid;
  logic [31:0] p_tg, p_addr, p_pc, p_instr;

  always @(negedge clk) begin
    logic [31:0] e;
    if (have_prev) begin
      chk("misalign_err", 32'(misalign_err), 32'(p_rn & p_rv & (|p_tg[1:0])));
      if (redirect_valid) begin
        chk("kill_in_redirect", 32'(if_id_valid), 32'd0);
      end else if (!p_rn) begin
        chk("valid_after_reset", 32'(if_id_valid), 32'd0);
        chk("addr_after_reset", imem_addr, 32'h4);
        chk("pc_after_reset", if_id_pc, 32'h0);
      end else if (p_rv) begin
        chk("bubble_after_redirect", 32'(if_id_valid), 32'd0);
        chk("addr_after_redirect", imem_addr, {p_tg[31:2], 2'b00});
      end else if (p_st) begin
        chk("stall_hold_valid", 32'(if_id_valid), 32'(p_valid));
        chk("stall_hold_pc", if_id_pc, p_pc);
        chk("stall_hold_instr", if_id_instr, p_instr);
        chk("stall_hold_addr", imem_addr, p_addr);
      end else begin
        chk("no_bubble", 32'(if_id_valid), 32'd1);
        chk("addr_advance", imem_addr, p_addr + 32'd4);
      end
    end
    if (!if_id_valid) chk("nop_when_invalid", if_id_instr, NOP_INSTR);
    if (rst_n && if_id_valid && !stall) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got pc %h expected none", if_id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_id_pc, e);
        chk("sb_instr", if_id_instr, mem_fn(e));
      end
    end
    p_rn = rst_n; p_st = stall; p_rv = redirect_valid; p_tg = redirect_target;
    p_valid = if_id_valid; p_addr = imem_addr; p_pc = if_id_pc; p_instr = if_id_instr;
    have_prev = 1'b1;
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c0_addr", imem_addr, 32'h4);
    chk("c0_valid", 32'(if_id_valid), 32'd0);
    chk("c0_instr", if_id_instr, NOP_INSTR);
    chk("c0_addr2", imem_addr2, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("c1_pc", if_id_pc, 32'h4);
    chk("c1_instr", if_id_instr, 32'h0091_0193);
    chk("wrap_pc0", if_id_pc2, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_pc", if_id_pc, 32'h8);
      chk("stall_instr", if_id_instr, 32'h0000_0033);
      chk("stall_valid", 32'(if_id_valid), 32'd1);
      if (i == 0) chk("wrap_pc1", if_id_pc2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_pc2", if_id_pc2, 32'h0000_0000);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("release_pc", if_id_pc, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("after_stall_pc", if_id_pc, 32'hC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pc16", if_id_pc, 32'h10);
    chk("instr16", if_id_instr, 32'h0051_8213);
    step(1'b1, 1'b0, 1'b1, 32'h10);
    chk("redir_t_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_t1_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_t2_pc", if_id_pc, 32'h10);
    chk("redir_t2_instr", if_id_instr, 32'h0051_8213);
    step(1'b1, 1'b1, 1'b1, 32'h42);
    chk("mis_t_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_addr", imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mis_clear", 32'(misalign_err), 32'd0);
    chk("mis_pc", if_id_pc, 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("fsm_hold", 32'(dut.u_hold.state_q), 32'(HOLD));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_hold_fsm", 32'(dut.u_hold.state_q), 32'(RUN));
    chk("rst_hold_valid", 32'(if_id_valid), 32'd0);
    chk("rst_hold_addr", imem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_hold_pc", if_id_pc, 32'h4);
    chk("rst_hold_instr", if_id_instr, 32'h0091_0193);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 150) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           $urandom_range(0, 1023));
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
